// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch (I) and data (D) requesters.
// Optional performance counters are compiled in with `define MEM_ARB_PERF_CNT_EN.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_STARVE = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_ready,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [DATA_WIDTH/8-1:0] d_be,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    output logic                    d_ready,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_ack,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    busy,
    output logic [31:0]             perf_conflict_cnt,
    output logic [31:0]             perf_starve_cnt
);
    localparam int BE_W = DATA_WIDTH / 8;
    localparam logic [3:0] MAX_S = 4'(MAX_STARVE);

    typedef enum logic [1:0] {ST_IDLE, ST_GRANT_I, ST_GRANT_D, ST_RESP} state_t;

    state_t                  state_q;
    logic [3:0]              starve_cnt_q;
    logic                    if_ready_q, d_ready_q, mem_req_q, mem_we_q, busy_q;
    logic [DATA_WIDTH-1:0]   if_rdata_q, d_rdata_q, mem_wdata_q;
    logic [BE_W-1:0]         mem_be_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;

    logic starve_full, grant_d, starve_forced;

    // I is only forced through when it has waited out MAX_STARVE contested D grants.
    assign starve_full   = (starve_cnt_q == MAX_S);
    assign grant_d       = d_req & ~(if_req & starve_full);
    assign starve_forced = d_req & if_req & starve_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            starve_cnt_q <= '0;
            if_ready_q   <= 1'b0;
            d_ready_q    <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            busy_q       <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
            mem_addr_q   <= '0;
        end else begin
            if_ready_q <= 1'b0;
            d_ready_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_d) begin
                        state_q     <= ST_GRANT_D;
                        busy_q      <= 1'b1;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= d_we;
                        mem_be_q    <= d_be;
                        mem_addr_q  <= d_addr;
                        mem_wdata_q <= d_wdata;
                        if (!if_req)
                            starve_cnt_q <= '0;
                        else if (!starve_full)
                            starve_cnt_q <= starve_cnt_q + 4'd1;
                    end else if (if_req) begin
                        state_q      <= ST_GRANT_I;
                        busy_q       <= 1'b1;
                        mem_req_q    <= 1'b1;
                        mem_we_q     <= 1'b0;
                        mem_be_q     <= {BE_W{1'b1}};
                        mem_addr_q   <= if_addr;
                        mem_wdata_q  <= '0;
                        starve_cnt_q <= '0;
                    end else begin
                        starve_cnt_q <= '0;
                    end
                end
                ST_GRANT_I: begin
                    if (mem_ack) begin
                        if_rdata_q <= mem_rdata;
                        if_ready_q <= 1'b1;
                        mem_req_q  <= 1'b0;
                        state_q    <= ST_RESP;
                    end
                end
                ST_GRANT_D: begin
                    if (mem_ack) begin
                        d_rdata_q <= mem_we_q ? '0 : mem_rdata;
                        d_ready_q <= 1'b1;
                        mem_req_q <= 1'b0;
                        state_q   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] perf_conflict_q, perf_starve_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_conflict_q <= '0;
            perf_starve_q   <= '0;
        end else if (state_q == ST_IDLE) begin
            if (if_req && d_req && perf_conflict_q != '1)
                perf_conflict_q <= perf_conflict_q + 32'd1;
            if (starve_forced && perf_starve_q != '1)
                perf_starve_q <= perf_starve_q + 32'd1;
        end
    end

    assign perf_conflict_cnt = perf_conflict_q;
    assign perf_starve_cnt   = perf_starve_q;
`else
    logic unused_perf;
    assign unused_perf       = starve_forced;
    assign perf_conflict_cnt = '0;
    assign perf_starve_cnt   = '0;
`endif

    assign if_ready  = if_ready_q;
    assign if_rdata  = if_rdata_q;
    assign d_ready   = d_ready_q;
    assign d_rdata   = d_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MS = 4;
`ifdef MEM_ARB_PERF_CNT_EN
    localparam int PERF_ON = 1;
`else
    localparam int PERF_ON = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ack = 1'b0;
    logic [AW-1:0] if_addr = '0, d_addr = '0;
    logic [DW-1:0] d_wdata = '0, mem_rdata = '0;
    logic [3:0]    d_be = '0;
    logic          if_ready, d_ready, mem_req, mem_we, busy;
    logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [31:0]   perf_conflict_cnt, perf_starve_cnt;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_STARVE(MS)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy),
        .perf_conflict_cnt(perf_conflict_cnt), .perf_starve_cnt(perf_starve_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Transaction-level model: who owns the memory, whether a response is due, waiting time of I.
    int            m_owner = 0;     // 0 none, 1 fetch, 2 data
    bit            m_resp  = 1'b0;
    int            m_starve = 0;
    logic          e_if_ready = 0, e_d_ready = 0, e_mem_req = 0, e_mem_we = 0, e_busy = 0;
    logic [DW-1:0] e_if_rdata = '0, e_d_rdata = '0, e_mem_wdata = '0;
    logic [3:0]    e_mem_be = '0;
    logic [AW-1:0] e_mem_addr = '0;
    logic [31:0]   e_conflict = '0, e_starve_perf = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        bit forced;
        if (rst) begin
            m_owner = 0; m_resp = 0; m_starve = 0;
            e_if_ready = 0; e_d_ready = 0; e_mem_req = 0; e_mem_we = 0; e_busy = 0;
            e_if_rdata = '0; e_d_rdata = '0; e_mem_wdata = '0; e_mem_be = '0; e_mem_addr = '0;
            e_conflict = '0; e_starve_perf = '0;
        end else begin
            e_if_ready = 0;
            e_d_ready  = 0;
            if (m_resp) begin
                m_resp = 0;
                e_busy = 0;
            end else if (m_owner != 0) begin
                if (mem_ack) begin
                    if (m_owner == 1) begin
                        e_if_rdata = mem_rdata;
                        e_if_ready = 1;
                    end else begin
                        e_d_rdata = e_mem_we ? '0 : mem_rdata;
                        e_d_ready = 1;
                    end
                    e_mem_req = 0;
                    m_owner   = 0;
                    m_resp    = 1;
                end
            end else begin
                forced = if_req && (m_starve == MS);
                if (PERF_ON != 0 && if_req && d_req && e_conflict != 32'hFFFF_FFFF)
                    e_conflict = e_conflict + 1;
                if (d_req && !forced) begin
                    m_owner = 2; e_busy = 1; e_mem_req = 1;
                    e_mem_we = d_we; e_mem_be = d_be; e_mem_addr = d_addr; e_mem_wdata = d_wdata;
                    m_starve = if_req ? ((m_starve < MS) ? m_starve + 1 : m_starve) : 0;
                end else if (if_req) begin
                    m_owner = 1; e_busy = 1; e_mem_req = 1;
                    e_mem_we = 0; e_mem_be = 4'hF; e_mem_addr = if_addr; e_mem_wdata = '0;
                    if (PERF_ON != 0 && forced && d_req && e_starve_perf != 32'hFFFF_FFFF)
                        e_starve_perf = e_starve_perf + 1;
                    m_starve = 0;
                end else begin
                    m_starve = 0;
                end
            end
        end
    endtask

    task automatic check_outputs();
        chk("if_ready", if_ready, e_if_ready);
        chk("d_ready", d_ready, e_d_ready);
        chk("busy", busy, e_busy);
        chk("mem_req", mem_req, e_mem_req);
        chk("perf_conflict", perf_conflict_cnt, e_conflict);
        chk("perf_starve", perf_starve_cnt, e_starve_perf);
        if (e_mem_req) begin
            chk("mem_addr", mem_addr, e_mem_addr);
            chk("mem_we", mem_we, e_mem_we);
            chk("mem_be", mem_be, e_mem_be);
            chk("mem_wdata", mem_wdata, e_mem_wdata);
        end
        if (e_if_ready) begin
            chk("if_rdata", if_rdata, e_if_rdata);
            $display("txn cyc=%0d fetch done rdata=%h", cyc, e_if_rdata);
        end
        if (e_d_ready) begin
            chk("d_rdata", d_rdata, e_d_rdata);
            $display("txn cyc=%0d data done rdata=%h", cyc, e_d_rdata);
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    initial begin
        string    exp_order;
        byte      order[$];
        logic     prev_req, prev_rdy;
        int       n_done, last, wait_cnt;

        // Reset state
        cycle();
        cycle();
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_if_ready", if_ready, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_mem_addr", mem_addr, 0);

        // Fetch only, memory acks two cycles after mem_req rises
        if_req = 1; if_addr = 32'h100;
        cycle();
        chk("fetch_req", mem_req, 1);
        chk("fetch_addr", mem_addr, 32'h100);
        chk("fetch_we", mem_we, 0);
        chk("fetch_be", mem_be, 4'hF);
        cycle();
        cycle();
        chk("fetch_hold", mem_req, 1);
        mem_ack = 1; mem_rdata = 32'h0050_0093;
        cycle();
        chk("fetch_ready", if_ready, 1);
        chk("fetch_rdata", if_rdata, 32'h0050_0093);
        if_req = 0; mem_ack = 0;
        cycle();
        chk("fetch_pulse_end", if_ready, 0);

        // Store
        d_req = 1; d_we = 1; d_addr = 32'hFFFF_FFF0; d_be = 4'h1; d_wdata = 32'hA;
        cycle();
        chk("store_we", mem_we, 1);
        chk("store_be", mem_be, 4'h1);
        chk("store_wdata", mem_wdata, 32'hA);
        chk("store_addr", mem_addr, 32'hFFFF_FFF0);
        mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
        cycle();
        chk("store_ready", d_ready, 1);
        chk("store_rdata", d_rdata, 0);
        d_req = 0; d_we = 0; mem_ack = 0;
        cycle();

        // Simultaneous requests: D first, I after RESP plus one IDLE cycle
        if_req = 1; if_addr = 32'h300;
        d_req = 1; d_addr = 32'h200; d_be = 4'hF;
        cycle();
        chk("sim_d_first", mem_addr, 32'h200);
        mem_ack = 1; mem_rdata = 32'h1234;
        cycle();
        chk("sim_d_ready", d_ready, 1);
        chk("sim_d_rdata", d_rdata, 32'h1234);
        d_req = 0; mem_ack = 0;
        cycle();
        chk("sim_idle_req", mem_req, 0);
        chk("sim_idle_busy", busy, 0);
        cycle();
        chk("sim_i_req", mem_req, 1);
        chk("sim_i_addr", mem_addr, 32'h300);
        mem_ack = 1;
        cycle();
        chk("sim_i_ready", if_ready, 1);
        if_req = 0; mem_ack = 0;
        cycle();

        // Starvation guard: fresh counters, I held, D always re-requesting
        rst = 1;
        cycle();
        rst = 0;
        if_req = 1; if_addr = 32'h400;
        d_req = 1; d_we = 0; d_addr = 32'h500;
        prev_req = 0;
        for (int k = 0; k < 80 && order.size() < 6; k++) begin
            mem_rdata = $urandom;
            cycle();
            if (mem_req && !prev_req) order.push_back((mem_addr == 32'h400) ? 8'h49 : 8'h44);
            prev_req = mem_req;
            mem_ack  = mem_req;
        end
        chk("starve_grants", order.size(), 6);
        exp_order = "DDDDID";
        for (int i = 0; i < 6 && i < order.size(); i++)
            chk("starve_order", order[i], exp_order[i]);
        chk("starve_perf", perf_starve_cnt, (PERF_ON != 0) ? 1 : 0);
        if_req = 0; d_req = 0;
        for (int k = 0; k < 6; k++) begin
            cycle();
            mem_ack = mem_req;
        end
        mem_ack = 0;
        cycle();
        chk("starve_drained", busy, 0);

        // Reset while D is granted and unacknowledged
        d_req = 1; d_we = 1; d_addr = 32'h800; d_be = 4'h3; d_wdata = 32'h5;
        cycle();
        chk("rstmid_req", mem_req, 1);
        rst = 1;
        cycle();
        rst = 0; d_req = 0; d_we = 0;
        chk("rstmid_mem_req", mem_req, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_ready", d_ready, 0);
        mem_ack = 1;
        cycle();
        chk("rstmid_late_ack", d_ready, 0);
        chk("rstmid_late_busy", busy, 0);
        mem_ack = 0;
        cycle();
        chk("rstmid_quiet", d_ready, 0);

        // Zero-wait memory, alternating fetch and load
        if_req = 1; if_addr = 32'h600; d_addr = 32'h700; d_we = 0; d_be = 4'hF;
        n_done = 0; last = -1; prev_rdy = 0;
        for (int k = 0; k < 40 && n_done < 6; k++) begin
            mem_rdata = $urandom;
            cycle();
            mem_ack = mem_req;
            chk("zw_width", prev_rdy & (if_ready | d_ready), 0);
            prev_rdy = if_ready | d_ready;
            if (if_ready || d_ready) begin
                if (last >= 0) chk("zw_interval", cyc - last, 3);
                last = cyc;
                n_done++;
                if (if_ready) begin if_req = 0; d_req = 1; end
                else begin d_req = 0; if_req = 1; end
            end
        end
        chk("zw_count", n_done, 6);
        if_req = 0; d_req = 0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            mem_ack = mem_req;
        end
        mem_ack = 0;

        // Randomized traffic with variable latency, stray acks and occasional resets
        wait_cnt = 0;
        for (int k = 0; k < 3000; k++) begin
            mem_rdata = $urandom;
            rst = ($urandom_range(0, 399) == 0);
            cycle();
            if (if_req && if_ready) begin
                if ($urandom_range(0, 1) == 1) if_addr = $urandom;
                else if_req = 0;
            end else if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1; if_addr = $urandom;
            end
            if (d_req && d_ready) begin
                if ($urandom_range(0, 1) == 1) begin
                    d_we = $urandom_range(0, 1); d_be = 4'($urandom_range(0, 15));
                    d_addr = $urandom; d_wdata = $urandom;
                end else d_req = 0;
            end else if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1; d_we = $urandom_range(0, 1); d_be = 4'($urandom_range(0, 15));
                d_addr = $urandom; d_wdata = $urandom;
            end
            if (mem_req) begin
                if (wait_cnt == 0) mem_ack = 1;
                else begin mem_ack = 0; wait_cnt--; end
            end else begin
                mem_ack  = ($urandom_range(0, 7) == 0);
                wait_cnt = $urandom_range(0, 3);
            end
        end
        rst = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the pipeline's instruction-fetch requester (I) and data-memory requester (D).
- Sits between the CPU's fetch/memory-stage interfaces and the memory/MMIO fabric.
- Fixed D-over-I priority, with a starvation guard that forces an I grant after MAX_STARVE consecutive contested D grants.
- One outstanding transaction; memory latency is variable and completed by mem_ack.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8.
- MAX_STARVE, 4, consecutive D grants allowed while I is waiting; range 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- if_req  in  1  fetch request; held until if_ready.
- if_addr  in  ADDR_WIDTH  fetch address.
- if_ready  out  1  one-cycle pulse: fetch done, if_rdata valid.
- if_rdata  out  DATA_WIDTH  fetched word.
- d_req  in  1  data request; held until d_ready.
- d_we  in  1  1 = store.
- d_be  in  DATA_WIDTH/8  byte enables.
- d_addr  in  ADDR_WIDTH  data address.
- d_wdata  in  DATA_WIDTH  store data.
- d_ready  out  1  one-cycle pulse: data access done.
- d_rdata  out  DATA_WIDTH  load data; 0 after stores.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  memory write enable.
- mem_be  out  DATA_WIDTH/8  memory byte enables.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_ack  in  1  memory completes the current request this cycle.
- mem_rdata  in  DATA_WIDTH  read data, valid with mem_ack.
- busy  out  1  high in GRANT_I, GRANT_D and RESP.
- perf_conflict_cnt  out  32  see Optional Feature.
- perf_starve_cnt  out  32  see Optional Feature.

Behaviour:
- Clock and reset: single clk; rst synchronous active-high.
- All outputs are registered and reset to 0.
- FSM states: IDLE, GRANT_I, GRANT_D, RESP. Reset puts the FSM in IDLE and clears starve_cnt.
- IDLE arbitration:
  - d_req & !(if_req & starve_cnt==MAX_STARVE) -> GRANT_D.
  - else if_req -> GRANT_I.
  - else stay in IDLE.
- Grant latch: on the grant edge, register mem_addr/mem_we/mem_be/mem_wdata and set mem_req=1.
  - Fetch grant drives mem_we=0, mem_be=all ones, mem_wdata=0.
  - mem_* are stable while mem_req=1.
- GRANT_x: wait for mem_ack. On mem_ack:
  - capture mem_rdata into the selected x_rdata (d_rdata=0 for a store).
  - mem_req=0 next cycle; go to RESP.
- RESP: the matching x_ready is high for exactly this cycle. Next state IDLE. Requests are not sampled in RESP.
- Minimum latency: request seen in cycle 0, mem_ack in cycle 1 -> x_ready in cycle 2. New arbitration in cycle 3.
- Requester contract:
  - Deassert req, or present a new request, in the cycle after ready.
  - A req dropped before ready is a protocol violation; the arbiter completes the granted access anyway.
- starve_cnt, width 4:
  - +1 on each D grant taken while if_req=1, saturating at MAX_STARVE.
  - Cleared on every I grant.
  - Cleared in IDLE when if_req=0.
- Boundary conditions:
  - mem_ack outside GRANT_x is ignored.
  - mem_ack in the same cycle mem_req first rises is legal.
  - if_req and d_req rising together with starve_cnt<MAX_STARVE -> D wins.
  - Reset mid-transaction: next edge gives IDLE, mem_req=0, no ready pulse; the memory must tolerate an abandoned request.

Optional Feature:
- Macro: MEM_ARB_PERF_CNT_EN.
- Defined:
  - perf_conflict_cnt +1 per IDLE cycle with if_req & d_req.
  - perf_starve_cnt +1 per I grant forced by starve_cnt==MAX_STARVE.
  - Both are 32-bit, saturating, and cleared by rst.
- Undefined: both ports are tied to 0 and no counter flops are inferred.

Test Plan:
- Fetch-only: if_req=1, if_addr=0x100, mem_ack 2 cycles after mem_req, mem_rdata=0x00500093 -> mem_addr=0x100, mem_we=0, mem_be=0xF; if_ready one pulse with if_rdata=0x00500093.
- Store: d_req=1, d_we=1, d_addr=0xFFFFFFF0, d_be=0x1, d_wdata=0xA -> mem_we=1, mem_be=0x1, mem_wdata=0xA; d_ready pulse with d_rdata=0.
- Simultaneous: if_req and d_req in the same cycle, d_addr=0x200 -> D served first, then I; I served after D's RESP plus one IDLE cycle.
- Starvation, MAX_STARVE=4: if_req held, d_req re-asserted after every d_ready -> grant order D,D,D,D,I,D...; with macro, perf_starve_cnt=1.
- Reset in GRANT_D before mem_ack -> next cycle mem_req=0, busy=0, no d_ready; a later mem_ack pulse is ignored.
- Zero-wait memory: mem_ack tied to mem_req, fetch and load alternating -> one completion every 3 cycles, each ready exactly one cycle wide.
